// File: rtl/cordic_fsm_ctrl_pkg.sv
// Shared types for the CORDIC sequencing controller: state encoding and
// variable-counter codes.
package cordic_fsm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_ITER,
    S_SHIFT,
    S_ADD,
    S_WAIT_ADD,
    S_STORE,
    S_NEXT_IT,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [1:0] VAR_X = 2'b00;
  localparam logic [1:0] VAR_Y = 2'b01;
  localparam logic [1:0] VAR_Z = 2'b10;

endpackage

// File: rtl/cordic_fsm_ctrl_if.sv
// Control bundle between the CORDIC FSM and its datapath/counters.
interface cordic_fsm_ctrl_if;

  logic       beg_FSM_CORDIC;
  logic       ACK_FSM_CORDIC;
  logic       operation;
  logic [1:0] shift_region_flag;
  logic [1:0] cont_var;
  logic       ready_add_subt;
  logic       max_tick_iter;
  logic       min_tick_iter;
  logic       max_tick_var;
  logic       min_tick_var;

  logic       reset_reg_cordic;
  logic       ready_CORDIC;
  logic       beg_add_subt;
  logic       ack_add_subt;
  logic       sel_mux_1;
  logic       sel_mux_3;
  logic [1:0] sel_mux_2;
  logic       mode;
  logic       enab_cont_iter;
  logic       load_cont_iter;
  logic       enab_cont_var;
  logic       load_cont_var;
  logic       enab_RB1;
  logic       enab_RB2;
  logic       enab_d_ff_Xn;
  logic       enab_d_ff_Yn;
  logic       enab_d_ff_Zn;
  logic       enab_d_ff_out;
  logic       enab_dff_shifted_x;
  logic       enab_dff_shifted_y;
  logic       enab_dff_LUT;
  logic       enab_dff_sign;

  modport fsm (
    input  beg_FSM_CORDIC, ACK_FSM_CORDIC, operation, shift_region_flag,
           cont_var, ready_add_subt, max_tick_iter, min_tick_iter,
           max_tick_var, min_tick_var,
    output reset_reg_cordic, ready_CORDIC, beg_add_subt, ack_add_subt,
           sel_mux_1, sel_mux_3, sel_mux_2, mode, enab_cont_iter,
           load_cont_iter, enab_cont_var, load_cont_var, enab_RB1, enab_RB2,
           enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn, enab_d_ff_out,
           enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT, enab_dff_sign
  );

  modport dp (
    output beg_FSM_CORDIC, ACK_FSM_CORDIC, operation, shift_region_flag,
           cont_var, ready_add_subt, max_tick_iter, min_tick_iter,
           max_tick_var, min_tick_var,
    input  reset_reg_cordic, ready_CORDIC, beg_add_subt, ack_add_subt,
           sel_mux_1, sel_mux_3, sel_mux_2, mode, enab_cont_iter,
           load_cont_iter, enab_cont_var, load_cont_var, enab_RB1, enab_RB2,
           enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn, enab_d_ff_out,
           enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT, enab_dff_sign
  );

endinterface

// File: rtl/cordic_fsm_ctrl.sv
// Moore sequencer for the iterative single-adder CORDIC: one add/sub per
// variable per iteration, then result latch and completion handshake.
//
// state      | meaning
// S_IDLE     | waiting for start request
// S_INIT     | clear datapath, load iteration/variable counters
// S_LOAD     | capture input operands
// S_ITER     | capture post-mux registers for this iteration
// S_SHIFT    | capture shifted X/Y, LUT angle and sign
// S_ADD      | launch adder for current variable
// S_WAIT_ADD | wait for adder result
// S_STORE    | latch result into Xn/Yn/Zn, advance variable counter
// S_NEXT_IT  | advance iteration or finish
// S_OUT      | latch final output
// S_DONE     | result valid until consumer acknowledges
module cordic_fsm_ctrl
  import cordic_fsm_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  cordic_fsm_ctrl_if.fsm   bus
);

  state_t r_state;
  state_t w_next;
  logic   w_unused;

  assign w_unused = bus.min_tick_var;

  // Selects follow the datapath inputs directly, regardless of state.
  assign bus.mode      = 1'b0;
  assign bus.sel_mux_2 = bus.cont_var;
  assign bus.sel_mux_1 = ~bus.min_tick_iter;
  assign bus.sel_mux_3 = bus.operation ^
                         ((bus.shift_region_flag == 2'b01) ||
                          (bus.shift_region_flag == 2'b10));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next                 = r_state;
    bus.reset_reg_cordic   = 1'b0;
    bus.ready_CORDIC       = 1'b0;
    bus.beg_add_subt       = 1'b0;
    bus.ack_add_subt       = 1'b0;
    bus.enab_cont_iter     = 1'b0;
    bus.load_cont_iter     = 1'b0;
    bus.enab_cont_var      = 1'b0;
    bus.load_cont_var      = 1'b0;
    bus.enab_RB1           = 1'b0;
    bus.enab_RB2           = 1'b0;
    bus.enab_d_ff_Xn       = 1'b0;
    bus.enab_d_ff_Yn       = 1'b0;
    bus.enab_d_ff_Zn       = 1'b0;
    bus.enab_d_ff_out      = 1'b0;
    bus.enab_dff_shifted_x = 1'b0;
    bus.enab_dff_shifted_y = 1'b0;
    bus.enab_dff_LUT       = 1'b0;
    bus.enab_dff_sign      = 1'b0;
    case (r_state)
      S_IDLE: if (bus.beg_FSM_CORDIC) w_next = S_INIT;
      S_INIT: begin
        bus.reset_reg_cordic = 1'b1;
        bus.load_cont_iter   = 1'b1;
        bus.load_cont_var    = 1'b1;
        w_next               = S_LOAD;
      end
      S_LOAD: begin
        bus.enab_RB1 = 1'b1;
        w_next       = S_ITER;
      end
      S_ITER: begin
        bus.enab_RB2 = 1'b1;
        w_next       = S_SHIFT;
      end
      S_SHIFT: begin
        bus.enab_dff_shifted_x = 1'b1;
        bus.enab_dff_shifted_y = 1'b1;
        bus.enab_dff_LUT       = 1'b1;
        bus.enab_dff_sign      = 1'b1;
        w_next                 = S_ADD;
      end
      S_ADD: begin
        bus.beg_add_subt = 1'b1;
        w_next           = S_WAIT_ADD;
      end
      S_WAIT_ADD: if (bus.ready_add_subt) w_next = S_STORE;
      S_STORE: begin
        bus.ack_add_subt  = 1'b1;
        bus.enab_cont_var = 1'b1;
        case (bus.cont_var)
          VAR_X:   bus.enab_d_ff_Xn = 1'b1;
          VAR_Y:   bus.enab_d_ff_Yn = 1'b1;
          VAR_Z:   bus.enab_d_ff_Zn = 1'b1;
          default: ;
        endcase
        // Variable counter wraps on its own after Z.
        w_next = bus.max_tick_var ? S_NEXT_IT : S_ADD;
      end
      S_NEXT_IT: begin
        if (bus.max_tick_iter) begin
          w_next = S_OUT;
        end else begin
          bus.enab_cont_iter = 1'b1;
          w_next             = S_ITER;
        end
      end
      S_OUT: begin
        bus.enab_d_ff_out = 1'b1;
        w_next            = S_DONE;
      end
      S_DONE: begin
        bus.ready_CORDIC = 1'b1;
        if (bus.ACK_FSM_CORDIC) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cordic_fsm_ctrl.sv
// Bench for cordic_fsm_ctrl: builds a per-cycle expected schedule of a whole
// CORDIC run from the operation's structure, drives noisy inputs, compares.
module tb_cordic_fsm_ctrl;

  localparam logic [17:0] M_RST = 18'h20000;
  localparam logic [17:0] M_RDY = 18'h10000;
  localparam logic [17:0] M_BEG = 18'h08000;
  localparam logic [17:0] M_ACK = 18'h04000;
  localparam logic [17:0] M_CIT = 18'h02000;
  localparam logic [17:0] M_LIT = 18'h01000;
  localparam logic [17:0] M_CV  = 18'h00800;
  localparam logic [17:0] M_LV  = 18'h00400;
  localparam logic [17:0] M_RB1 = 18'h00200;
  localparam logic [17:0] M_RB2 = 18'h00100;
  localparam logic [17:0] M_XN  = 18'h00080;
  localparam logic [17:0] M_YN  = 18'h00040;
  localparam logic [17:0] M_ZN  = 18'h00020;
  localparam logic [17:0] M_OUT = 18'h00010;
  localparam logic [17:0] M_SHF = 18'h0000F;

  typedef struct {
    logic [17:0] exp;
    logic        beg;
    logic        ack;
    logic        rdy;
    logic [1:0]  cv;
    logic        mn;
    logic        mx;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  int   first_wait;
  step_t sched[$];

  cordic_fsm_ctrl_if bus ();

  cordic_fsm_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [17:0] w_obs;
  logic [4:0]  w_sel;
  assign w_obs = {bus.reset_reg_cordic, bus.ready_CORDIC, bus.beg_add_subt,
                  bus.ack_add_subt, bus.enab_cont_iter, bus.load_cont_iter,
                  bus.enab_cont_var, bus.load_cont_var, bus.enab_RB1,
                  bus.enab_RB2, bus.enab_d_ff_Xn, bus.enab_d_ff_Yn,
                  bus.enab_d_ff_Zn, bus.enab_d_ff_out, bus.enab_dff_shifted_x,
                  bus.enab_dff_shifted_y, bus.enab_dff_LUT, bus.enab_dff_sign};
  assign w_sel = {bus.mode, bus.sel_mux_1, bus.sel_mux_3, bus.sel_mux_2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic nz();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] exp_sel();
    logic s3;
    s3 = bus.operation ^ ((bus.shift_region_flag == 2'b01) ||
                          (bus.shift_region_flag == 2'b10));
    return {1'b0, ~bus.min_tick_iter, s3, bus.cont_var};
  endfunction

  function automatic void push(logic [17:0] e, logic b, logic a, logic r,
                               int v, logic mn, logic mx);
    step_t s;
    s.exp = e; s.beg = b; s.ack = a; s.rdy = r;
    s.cv = 2'(v); s.mn = mn; s.mx = mx;
    sched.push_back(s);
  endfunction

  // One complete operation of n_it iterations; fixed_wait = 0 means random
  // adder latency. Non-qualified inputs carry random noise everywhere.
  task automatic build(input int n_it, input int fixed_wait);
    int idle_n, done_n, w;
    logic mn, mx;
    logic [17:0] en_var;
    sched.delete();
    first_wait = -1;
    idle_n = $urandom_range(1, 3);
    for (int k = 0; k < idle_n; k++) push(18'h0, k == idle_n - 1, nz(), nz(), 0, 1'b1, 1'b0);
    push(M_RST | M_LIT | M_LV, nz(), nz(), nz(), 0, 1'b1, n_it == 1);
    push(M_RB1, nz(), nz(), nz(), 0, 1'b1, n_it == 1);
    for (int it = 0; it < n_it; it++) begin
      mn = (it == 0);
      mx = (it == n_it - 1);
      push(M_RB2, nz(), nz(), nz(), 0, mn, mx);
      push(M_SHF, nz(), nz(), 1'b1, 0, mn, mx);
      for (int v = 0; v < 3; v++) begin
        push(M_BEG, nz(), nz(), nz(), v, mn, mx);
        w = (fixed_wait > 0) ? fixed_wait : int'($urandom_range(1, 4));
        for (int k = 0; k < w; k++) begin
          if (first_wait < 0) first_wait = sched.size();
          push(18'h0, nz(), nz(), k == w - 1, v, mn, mx);
        end
        en_var = (v == 0) ? M_XN : (v == 1) ? M_YN : M_ZN;
        push(M_ACK | M_CV | en_var, nz(), nz(), nz(), v, mn, mx);
      end
      push(mx ? 18'h0 : M_CIT, nz(), nz(), nz(), 0, mn, mx);
    end
    push(M_OUT, nz(), nz(), nz(), 0, n_it == 1, 1'b1);
    done_n = $urandom_range(1, 3);
    for (int k = 0; k < done_n; k++)
      push(M_RDY, (k == 0) ? 1'b1 : nz(), k == done_n - 1, nz(), 0, n_it == 1, 1'b1);
    push(18'h0, 1'b0, nz(), nz(), 0, 1'b1, 1'b0);
  endtask

  // Entered and left just after a rising edge.
  task automatic run(input int limit);
    step_t s;
    for (int i = 0; i < limit; i++) begin
      s = sched[i];
      bus.beg_FSM_CORDIC    = s.beg;
      bus.ACK_FSM_CORDIC    = s.ack;
      bus.ready_add_subt    = s.rdy;
      bus.cont_var          = s.cv;
      bus.min_tick_iter     = s.mn;
      bus.max_tick_iter     = s.mx;
      bus.max_tick_var      = (s.cv == 2'd2);
      bus.min_tick_var      = (s.cv == 2'd0);
      bus.operation         = nz();
      bus.shift_region_flag = 2'($urandom_range(0, 3));
      @(negedge clk);
      chk("out", 32'(w_obs), 32'(s.exp));
      chk("sel", 32'(w_sel), 32'(exp_sel()));
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_check(input string tag, input logic op, input logic [1:0] fl,
                            input logic [1:0] cv, input logic [4:0] sel);
    bus.beg_FSM_CORDIC    = 1'b0;
    bus.operation         = op;
    bus.shift_region_flag = fl;
    bus.cont_var          = cv;
    bus.min_tick_iter     = 1'b0;
    @(negedge clk);
    chk(tag, 32'(w_obs), 32'h0);
    chk({tag, "_sel"}, 32'(w_sel), 32'(sel));
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.beg_FSM_CORDIC = 1'b0; bus.ACK_FSM_CORDIC = 1'b0; bus.operation = 1'b0;
    bus.shift_region_flag = 2'b00; bus.cont_var = 2'b00; bus.ready_add_subt = 1'b0;
    bus.max_tick_iter = 1'b0; bus.min_tick_iter = 1'b1;
    bus.max_tick_var = 1'b0; bus.min_tick_var = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // sel_mux_3 table, sel_mux_1 = 1 with min_tick_iter = 0, sel_mux_2 = cv
    idle_check("rst_s3a", 1'b0, 2'b00, 2'b00, 5'b01000);
    idle_check("rst_s3b", 1'b0, 2'b01, 2'b01, 5'b01101);
    idle_check("rst_s3c", 1'b1, 2'b10, 2'b10, 5'b01010);
    idle_check("rst_s3d", 1'b1, 2'b11, 2'b11, 5'b01111);

    build(1, 3); run(sched.size());
    build(2, 0); run(sched.size());

    build(2, 3); run(first_wait + 1);
    reset = 1'b1;
    @(posedge clk); #1;
    idle_check("midrst1", 1'b0, 2'b00, 2'b10, 5'b01010);
    reset = 1'b0;
    idle_check("midrst2", 1'b0, 2'b00, 2'b01, 5'b01001);

    for (int t = 0; t < 6; t++) begin
      build(int'($urandom_range(1, 4)), 0);
      run(sched.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
